// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider bank: default counter width,
// per-channel state encoding and the divisor saturation helper.
package clk_div_pkg;

  localparam int CLKDIV_CNT_W = 17;

  typedef enum logic [1:0] {
    PARK     = 2'd0,
    RUN_LO   = 2'd1,
    RUN_HI   = 2'd2,
    STOPPING = 2'd3
  } ch_state_e;

  // A half-period of zero would stall the counter, so it is read as one.
  function automatic logic [31:0] sat_half(input logic [31:0] half);
    if (half == 32'd0) begin
      sat_half = 32'd1;
    end else begin
      sat_half = half;
    end
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One integer clock-divider channel: 50% duty output with a shadowed
// half-period that is swapped in only at a toggle boundary (or at once while
// parked / on a phase resync).
// Optional rising-edge strobe: define CLKDIV_STROBE_EN.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CLKDIV_CNT_W,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             load,
  input  logic             sync,
  output logic             clk_out,
  output logic             pend
`ifdef CLKDIV_STROBE_EN
  ,
  output logic             stb
`endif
);

  ch_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] act_r, act_s;
  logic [CNT_W-1:0] shd_r, shd_s;
  logic             pend_r, pend_s;
  logic             out_r, out_s;
  logic [CNT_W-1:0] eff_s;
  logic [CNT_W-1:0] half_s;
  logic             at_end_s;
  logic             apply_s;

  // Next-state and datapath decode; sync outranks counting, load is merged last.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    apply_s = 1'b0;
    // A parked channel uses its pending divisor immediately.
    eff_s    = ((state_r == PARK) && pend_r) ? shd_r : act_r;
    half_s   = CNT_W'(sat_half(32'(eff_s)));
    at_end_s = (cnt_r >= (half_s - CNT_W'(1)));

    if (sync) begin
      cnt_s   = '0;
      out_s   = 1'b0;
      apply_s = pend_r;
      if (en) begin
        state_s = RUN_LO;
      end else begin
        state_s = PARK;
      end
    end else begin
      case (state_r)
        PARK: begin
          apply_s = pend_r;
          if (!en) begin
            cnt_s   = '0;
            state_s = PARK;
          end else if (at_end_s) begin
            cnt_s   = '0;
            out_s   = 1'b1;
            state_s = RUN_HI;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            state_s = RUN_LO;
          end
        end
        RUN_LO: begin
          if (!en) begin
            cnt_s   = '0;
            state_s = PARK;
          end else if (at_end_s) begin
            cnt_s   = '0;
            out_s   = 1'b1;
            apply_s = pend_r;
            state_s = RUN_HI;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            state_s = RUN_LO;
          end
        end
        RUN_HI, STOPPING: begin
          // The high phase always completes; en only decides where it lands.
          if (at_end_s) begin
            cnt_s   = '0;
            out_s   = 1'b0;
            apply_s = pend_r;
            state_s = en ? RUN_LO : PARK;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            state_s = en ? RUN_HI : STOPPING;
          end
        end
        default: begin
          cnt_s   = '0;
          out_s   = 1'b0;
          state_s = PARK;
        end
      endcase
    end

    // The swap uses the pre-edge shadow; a load on this edge stays pending.
    act_s  = apply_s ? shd_r : act_r;
    shd_s  = load ? div : shd_r;
    pend_s = load | (pend_r & ~apply_s);
  end

  // Channel state registers with synchronous reset to the default divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PARK;
      cnt_r   <= '0;
      act_r   <= DEF_HALF;
      shd_r   <= DEF_HALF;
      pend_r  <= 1'b0;
      out_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      act_r   <= act_s;
      shd_r   <= shd_s;
      pend_r  <= pend_s;
      out_r   <= out_s;
    end
  end

  assign clk_out = out_r;
  assign pend    = pend_r;

`ifdef CLKDIV_STROBE_EN
  logic stb_r;

  // Strobe register set on the same edge that raises the divided clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_r <= 1'b0;
    end else begin
      stb_r <= out_s & ~out_r;
    end
  end

  assign stb = stb_r;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers sharing one system clock,
// synchronous reset and a global phase resync.
// Optional per-channel rising-edge strobe output: define CLKDIV_STROBE_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = CLKDIV_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {17'd50, 17'd2}
) (
  input  logic                    inclk0,
  input  logic                    areset,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       pend_o
`ifdef CLKDIV_STROBE_EN
  ,
  output logic [NUM_CH-1:0]       stb_o
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk     (inclk0),
      .rst     (areset),
      .en      (en_i[g]),
      .div     (div_i[g*CNT_W +: CNT_W]),
      .load    (load_i[g]),
      .sync    (sync_i),
      .clk_out (clk_o[g]),
      .pend    (pend_o[g])
`ifdef CLKDIV_STROBE_EN
      ,
      .stb     (stb_o[g])
`endif
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: hand-derived vector table, directed
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_clk_div_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 17;

  logic                    inclk0 = 1'b0;
  logic                    areset;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH*CNT_W-1:0] div_i;
  logic [NUM_CH-1:0]       load_i;
  logic                    sync_i;
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       pend_o;
`ifdef CLKDIV_STROBE_EN
  logic [NUM_CH-1:0]       stb_o;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: one entry per channel, plain integers.
  int m_cnt [NUM_CH];
  int m_act [NUM_CH];
  int m_shd [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_out [NUM_CH];
  bit m_park[NUM_CH];
  bit m_stb [NUM_CH];
  int defh  [NUM_CH] = '{2, 50};

  always #5 inclk0 = ~inclk0;

  clk_div_bank dut (
    .inclk0 (inclk0),
    .areset (areset),
    .en_i   (en_i),
    .div_i  (div_i),
    .load_i (load_i),
    .sync_i (sync_i),
    .clk_o  (clk_o),
    .pend_o (pend_o)
`ifdef CLKDIV_STROBE_EN
    ,
    .stb_o  (stb_o)
`endif
  );

  task automatic check_v(input string name, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Apply the rules of one rising edge to the model, using the current inputs.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      int h;
      bit was_out;
      bit running;
      was_out = m_out[c];
      if (areset) begin
        m_cnt[c] = 0; m_out[c] = 0; m_pend[c] = 0;
        m_act[c] = defh[c]; m_shd[c] = defh[c]; m_park[c] = 1;
      end else begin
        if (sync_i) begin
          m_cnt[c] = 0; m_out[c] = 0;
          if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
          m_park[c] = !en_i[c];
        end else begin
          if (m_park[c] && m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
          running = m_out[c] || en_i[c];
          if (!running) begin
            m_cnt[c] = 0; m_park[c] = 1;
          end else begin
            h = (m_act[c] == 0) ? 1 : m_act[c];
            m_park[c] = 0;
            if (m_cnt[c] < h - 1) begin
              m_cnt[c]++;
            end else begin
              m_out[c] = !m_out[c];
              m_cnt[c] = 0;
              if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
              if (!m_out[c] && !en_i[c]) m_park[c] = 1;
            end
          end
        end
        if (load_i[c]) begin
          m_shd[c]  = int'(div_i[c*CNT_W +: CNT_W]);
          m_pend[c] = 1;
        end
      end
      m_stb[c] = !was_out && m_out[c];
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge,
  // then single-cycle pulses are cleared.
  task automatic cycle();
    @(posedge inclk0);
    model_edge();
    @(negedge inclk0);
    check_v("model clk_o", clk_o, {m_out[1], m_out[0]});
    check_v("model pend_o", pend_o, {m_pend[1], m_pend[0]});
`ifdef CLKDIV_STROBE_EN
    check_v("model stb_o", stb_o, {m_stb[1], m_stb[0]});
`endif
    load_i = '0;
    sync_i = 1'b0;
  endtask

  // Count edges until clk_o[ch] equals val; returns bound+1 on timeout.
  task automatic run_until(input int ch, input logic val, input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (clk_o[ch] !== val && n <= bound);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle();
    areset = 1'b0;
  endtask

  typedef struct {
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] load;
    logic [CNT_W-1:0]  d0;
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_pend;
  } vec_t;

  vec_t vt[15];

  initial begin
    int n;
    logic prev;

    areset = 1'b1; en_i = 2'b11; div_i = '0; load_i = '0; sync_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_out[c] = 0; m_pend[c] = 0; m_act[c] = defh[c];
      m_shd[c] = defh[c]; m_park[c] = 1; m_stb[c] = 0;
    end

    // Reset release, ch0 H=2, load 5 into ch0 during its high phase.
    vt[0]  = '{1'b1, 2'b11, 2'b00, 17'd0, 2'b00, 2'b00};
    vt[1]  = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b00, 2'b00};
    vt[2]  = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b01, 2'b00};
    vt[3]  = '{1'b0, 2'b11, 2'b01, 17'd5, 2'b01, 2'b01};
    vt[4]  = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b00, 2'b00};
    for (int i = 5; i <= 8; i++)  vt[i] = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b00, 2'b00};
    for (int i = 9; i <= 13; i++) vt[i] = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b01, 2'b00};
    vt[14] = '{1'b0, 2'b11, 2'b00, 17'd0, 2'b00, 2'b00};

    for (int i = 0; i < 15; i++) begin
      areset = vt[i].rst;
      en_i   = vt[i].en;
      load_i = vt[i].load;
      div_i  = {17'd0, vt[i].d0};
      cycle();
      check_v($sformatf("vec%0d clk_o", i), clk_o, vt[i].exp_clk);
      check_v($sformatf("vec%0d pend_o", i), pend_o, vt[i].exp_pend);
    end

    // Default ch1: first rise at edge 50, high for 50.
    do_reset();
    run_until(1, 1'b1, 200, n);
    check_i("ch1 first rise edge", n, 50);
    // Drop en_i[1] with cnt=10 in the high phase.
    for (int i = 0; i < 10; i++) cycle();
    en_i = 2'b01;
    run_until(1, 1'b0, 200, n);
    check_i("ch1 stopping fall edge", n, 40);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_v("ch1 parked low", {1'b0, clk_o[1]}, 2'b00);
    end
    en_i = 2'b11;
    run_until(1, 1'b1, 200, n);
    check_i("ch1 re-enable rise edge", n, 50);

    // Load 0 into ch1 during its high phase: toggles every cycle afterwards.
    load_i = 2'b10;
    div_i  = {17'd0, 17'd0};
    cycle();
    check_v("ch1 pend after load", {1'b0, pend_o[1]}, 2'b01);
    run_until(1, 1'b0, 200, n);
    check_i("ch1 boundary edge", n, 49);
    check_v("ch1 pend after boundary", {1'b0, pend_o[1]}, 2'b00);
    for (int i = 0; i < 6; i++) begin
      prev = clk_o[1];
      cycle();
      check_v("ch1 H=0 toggles", {1'b0, clk_o[1]}, {1'b0, ~prev});
    end

    // sync plus load on a ch0 toggle edge with an older load pending.
    do_reset();
    load_i = 2'b01; div_i = {17'd0, 17'd3};
    cycle();
    sync_i = 1'b1; load_i = 2'b01; div_i = {17'd0, 17'd7};
    cycle();
    check_v("sync clk_o", clk_o, 2'b00);
    check_v("sync pend_o", pend_o, 2'b01);
    run_until(0, 1'b1, 20, n);
    check_i("ch0 rise after sync", n, 3);
    check_v("ch0 pend after rise", {1'b0, pend_o[0]}, 2'b00);
    run_until(0, 1'b0, 20, n);
    check_i("ch0 high with new H", n, 7);

    // Reset in the middle of a run with a pending load.
    for (int i = 0; i < 13; i++) cycle();
    load_i = 2'b10; div_i = {17'd9, 17'd0};
    cycle();
    check_v("pend before reset", {1'b0, pend_o[1]}, 2'b01);
    do_reset();
    check_v("reset clk_o", clk_o, 2'b00);
    check_v("reset pend_o", pend_o, 2'b00);
    run_until(1, 1'b1, 200, n);
    check_i("ch1 rise after reset", n, 50);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      areset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en_i[0] = ~en_i[0];
      if ($urandom_range(0, 39) == 0) en_i[1] = ~en_i[1];
      load_i[0] = ($urandom_range(0, 7) == 0);
      load_i[1] = ($urandom_range(0, 7) == 0);
      div_i  = {17'($urandom_range(0, 12)), 17'($urandom_range(0, 7))};
      sync_i = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent integer clock dividers for the SD/WM8731 WAV-decode design, generating the codec-side and slow housekeeping clocks from one system clock. Each channel produces a 50%-duty divided clock with a runtime-programmable half-period, and applies divisor changes glitch-free at the next toggle boundary. Channels support per-channel enable and a global phase-resync. An optional per-channel rising-edge strobe can be compiled in.

## Interface
Parameters:
- NUM_CH, 2: number of divider channels.
- CNT_W, 17: counter and divisor width per channel.
- DEF_HALF, {17'd50, 17'd2}: packed NUM_CH×CNT_W reset half-periods. Channel 0 is the LSB slice.

Ports:
- inclk0, in, 1: system clock. All logic is on its rising edge.
- areset, in, 1: synchronous, active-high reset.
- en_i, in, NUM_CH: per-channel run enable.
- div_i, in, NUM_CH×CNT_W: new half-period per channel.
- load_i, in, NUM_CH: per-channel single-cycle pulse that captures the div_i slice.
- sync_i, in, 1: single-cycle global phase restart.
- clk_o, out, NUM_CH: divided clocks.
- pend_o, out, NUM_CH: a loaded divisor is waiting for its boundary.
- stb_o, out, NUM_CH: rising-edge strobe. Present only with CLKDIV_STROBE_EN.

## Operation
- Per-channel state:
  - cnt (CNT_W bits)
  - act (active half-period)
  - shd (shadow half-period)
  - pend flag
  - out register
- Reset (areset=1 at an edge), per channel:
  - cnt=0, out=0, pend=0, stb=0.
  - act=shd=DEF_HALF slice.
  - Reset overrides every other input and aborts any pending load.
- Divisor 0 is treated as 1 wherever it is used, so a channel can never stall.
- Counting (en_i=1, channel running):
  - If cnt < act-1: cnt <= cnt+1.
  - Else (toggle edge): out <= ~out, cnt <= 0.
  - On a toggle edge with pend=1: act <= shd, pend <= 0.
- Load: on load_i[i], shd <= div_i slice and pend <= 1.
  - Load on the same edge as a toggle: the toggle uses the old pend and shd state. The new value waits for the following toggle.
  - Repeated loads before the boundary: the last one wins.
- Enable:
  - en_i deasserted while out=1: the channel keeps counting until its falling toggle, then parks with out=0 and cnt=0.
  - en_i deasserted while out=0: the channel parks immediately (cnt <= 0).
  - Parked channel: a pending divisor is applied at once (act <= shd, pend <= 0).
  - en_i reasserted: counting restarts from cnt=0 with out=0.
- sync_i, all channels: cnt <= 0 and out <= 0. Pending divisors are applied. Takes priority over toggle and load on the same edge; a load on the sync edge still sets shd and pend.
- States per channel: PARK, RUN_LO, RUN_HI, STOPPING.
  - PARK→RUN_LO when en=1.
  - RUN_LO↔RUN_HI on toggle.
  - RUN_HI→STOPPING when en=0.
  - STOPPING→PARK on the falling toggle.
  - RUN_LO→PARK when en=0.

## Timing
- Half-period H: clk_o toggles every H inclk0 cycles, giving period 2H.
- From reset release, or the first enabled edge, the first rise occurs on the H-th rising edge.
- Divisor update latency: applied on the first toggle edge strictly after the load edge. pend_o drops on that edge.
- Reset value of every output is 0.
- All outputs are registered, with no combinational path from any input to any output.

## Configuration
- CLKDIV_STROBE_EN defined:
  - stb_o[i] is 1 for exactly one inclk0 cycle, in the cycle after clk_o[i] goes 0→1 (registered together with out).
  - It serves as a clock-enable for downstream logic in the inclk0 domain.
- CLKDIV_STROBE_EN undefined: the stb_o port and its logic are absent.

## Structure
- Package clk_div_pkg holds:
  - CNT_W default
  - typedef of the per-channel state enum (PARK, RUN_LO, RUN_HI, STOPPING)
  - the "divisor 0→1" saturation function
- Sub-module clk_div_ch implements one channel. clk_div_bank instantiates NUM_CH copies through a generate loop and slices div_i and DEF_HALF.

## Test plan
- Reset release with defaults, en_i=2'b11:
  - clk_o[0] toggles every 2 cycles, first rise at edge 2.
  - clk_o[1] toggles every 50 cycles, first rise at edge 50.
- Load 5 into ch0 mid-high-phase: the current phase finishes with H=2, then all subsequent phases are 5 cycles. pend_o[0] stays high until that toggle.
- Load 0 into ch1: it toggles every cycle after the boundary; there is no stall.
- Drop en_i[1] while clk_o[1]=1 at cnt=10: it stays high 39 more cycles, falls, and parks low. Re-enabling gives its first rise 50 cycles later.
- Assert sync_i and load_i[0] on the same edge as a ch0 toggle:
  - Both clocks go 0 with cnt=0 on that edge.
  - The old pending value is applied.
  - The new load stays pending.
- Assert areset mid-run with pend=1: all outputs 0 next cycle, act equals DEF_HALF, pend_o=0. With CLKDIV_STROBE_EN, stb_o pulses once per rise only.
